// File: rtl/cache_pkg.sv
// Shared cache definitions: fill FSM state encoding, block geometry and the
// block-align mask. Used by the instruction-cache fill FSM, the cache itself
// and the data-cache FSM.
package cache_pkg;

    // Refill controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        META   = 2'd2,
        SETTLE = 2'd3
    } fill_state_t;

    // Block geometry: 8 halfword-sized words, offset = addr[3:1]
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned OFFSET_LSB  = 1;
    localparam int unsigned OFFSET_MSB  = 3;
    localparam int unsigned OFFSET_W    = OFFSET_MSB - OFFSET_LSB + 1;
    localparam int unsigned CNT_W       = $clog2(BLOCK_WORDS + 1);

    // Clears the byte-in-block bits; wide enough to be truncated to any address width
    localparam logic [63:0] BLOCK_ALIGN_MASK = ~64'((64'd1 << (OFFSET_MSB + 1)) - 64'd1);

endpackage

// File: rtl/fill_word_counter.sv
// Saturating 0..LIMIT word counter with a terminal-count flag.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - synchronous clear to zero (wins over inc)
//   inc        - advance by one; ignored once the limit is reached
//   count      - current count
//   done_c     - combinational, high when count == LIMIT
module fill_word_counter #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             done_c
);

    assign done_c = (count == CNT_W'(LIMIT));

    // Count register, holds at LIMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !done_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Instruction-cache miss refill controller. On a miss it streams the 8-word
// block from a pipelined memory into the cache fill port, then pulses the
// metadata write and waits one settle cycle before sampling miss again.
// Optional build macro: CACHE_FILL_CRIT_WORD_EN enables critical-word-first
// wrap ordering; when undefined the fill always starts at offset 0.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   miss, miss_addr - cache miss level and the missing CPU address
//   fsm_busy        - fill in progress (fetch stall)
//   addr_fsm        - cache fill address (word select = addr_fsm[3:1])
//   data_fsm        - cache fill data
//   data_we         - cache data write enable, one word per pulse
//   metadata_we     - cache metadata write enable, single-cycle pulse
//   mem_en, mem_addr          - memory read request and address
//   mem_data, mem_data_valid  - memory read return, in request order
// All outputs are combinational from state, counters and memory inputs.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              fsm_busy,
    output logic [ADDR_W-1:0] addr_fsm,
    output logic [DATA_W-1:0] data_fsm,
    output logic              data_we,
    output logic              metadata_we,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid
);

    fill_state_t         state;
    fill_state_t         state_nxt;
    logic [ADDR_W-1:0]   base;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    recv_cnt;
    logic                issue_done_c;
    logic                recv_done_c;
    logic [OFFSET_W-1:0] issue_word;
    logic [OFFSET_W-1:0] recv_word;
    logic                counters_clr;
    logic                unused_issue_msb;

    // Counters are held at zero whenever no fill is running
    assign counters_clr = (state == IDLE);

    fill_word_counter #(
        .LIMIT (BLOCK_WORDS),
        .CNT_W (CNT_W)
    ) u_issue_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (counters_clr),
        .inc    (mem_en),
        .count  (issue_cnt),
        .done_c (issue_done_c)
    );

    fill_word_counter #(
        .LIMIT (BLOCK_WORDS),
        .CNT_W (CNT_W)
    ) u_recv_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (counters_clr),
        .inc    (data_we),
        .count  (recv_cnt),
        .done_c (recv_done_c)
    );

    // Only the low offset bits select a word; the MSB just marks "all issued"
    assign unused_issue_msb = issue_cnt[CNT_W-1];

`ifdef CACHE_FILL_CRIT_WORD_EN
    logic [OFFSET_W-1:0] crit;

    // Critical word offset, captured with the block base
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit <= '0;
        end else if (state == IDLE && miss) begin
            crit <= miss_addr[OFFSET_MSB:OFFSET_LSB];
        end
    end

    // Wrap ordering: offset arithmetic stays inside the block (no carry into base)
    assign issue_word = OFFSET_W'(crit + issue_cnt[OFFSET_W-1:0]);
    assign recv_word  = OFFSET_W'(crit + recv_cnt[OFFSET_W-1:0]);
`else
    assign issue_word = issue_cnt[OFFSET_W-1:0];
    assign recv_word  = recv_cnt[OFFSET_W-1:0];
`endif

    // Block-aligned base of the missing address, frozen for the whole fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
        end else if (state == IDLE && miss) begin
            base <= miss_addr & ADDR_W'(BLOCK_ALIGN_MASK);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt   = state;
        fsm_busy    = 1'b0;
        addr_fsm    = '0;
        data_fsm    = '0;
        data_we     = 1'b0;
        metadata_we = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = '0;

        case (state)
            IDLE: begin
                if (miss) begin
                    state_nxt = FILL;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;
                addr_fsm = base;
                // Issue and receive sides run independently
                if (!issue_done_c) begin
                    mem_en   = 1'b1;
                    mem_addr = base | ADDR_W'({issue_word, OFFSET_LSB'(0)});
                end
                if (mem_data_valid && !recv_done_c) begin
                    data_we  = 1'b1;
                    addr_fsm = base | ADDR_W'({recv_word, OFFSET_LSB'(0)});
                    data_fsm = mem_data;
                    if (recv_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
                        state_nxt = META;
                    end
                end
            end

            META: begin
                fsm_busy    = 1'b1;
                metadata_we = 1'b1;
                addr_fsm    = base;
                state_nxt   = SETTLE;
            end

            SETTLE: begin
                // Cache commits metadata one cycle after metadata_we
                fsm_busy  = 1'b1;
                addr_fsm  = base;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm with a fixed-latency (4) pipelined
// memory model. Expected fill addresses/data are queued when a miss is
// driven and popped when the DUT issues requests or writes the cache.
module tb_cache_fill_fsm;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss;
    logic [15:0] miss_addr;
    logic        fsm_busy;
    logic [15:0] addr_fsm;
    logic [15:0] data_fsm;
    logic        data_we;
    logic        metadata_we;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_data_valid;
    logic        stray_v;

    logic [LAT-1:0]       pv = '0;
    logic [LAT-1:0][15:0] pd = '0;

    logic [15:0] exp_issue[$];
    logic [15:0] exp_write[$];
    logic [15:0] exp_meta[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_we     = 0;
    int n_meta   = 0;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .miss           (miss),
        .miss_addr      (miss_addr),
        .fsm_busy       (fsm_busy),
        .addr_fsm       (addr_fsm),
        .data_fsm       (data_fsm),
        .data_we        (data_we),
        .metadata_we    (metadata_we),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid)
    );

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a ^ 16'h5A5A) + 16'h0137;
    endfunction

    function automatic logic [15:0] exp_addr(input logic [15:0] a, input int i);
        logic [2:0] w;
`ifdef CACHE_FILL_CRIT_WORD_EN
        w = 3'(a[3:1] + 3'(i));
`else
        w = 3'(i);
`endif
        return (a & 16'hFFF0) | {12'h000, w, 1'b0};
    endfunction

    // Memory: requests are not cancelled by the controller's reset
    always @(posedge clk) begin
        pv <= {pv[LAT-2:0], mem_en};
        pd <= {pd[LAT-2:0], mem_fn(mem_addr)};
    end
    assign mem_data_valid = pv[LAT-1] | stray_v;
    assign mem_data       = stray_v ? 16'hDEAD : pd[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input logic [15:0] a);
        for (int i = 0; i < 8; i++) begin
            exp_issue.push_back(exp_addr(a, i));
            exp_write.push_back(exp_addr(a, i));
        end
        exp_meta.push_back(a & 16'hFFF0);
    endtask

    task automatic start_miss(input logic [15:0] a);
        miss      = 1'b1;
        miss_addr = a;
        push_fill(a);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!fsm_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_meta();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (metadata_we) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("meta_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(fsm_busy), 32'd0);
        check({tag, "_data_we"}, 32'(data_we), 32'd0);
        check({tag, "_meta_we"}, 32'(metadata_we), 32'd0);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_addr_fsm"}, 32'(addr_fsm), 32'd0);
        check({tag, "_data_fsm"}, 32'(data_fsm), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    endtask

    // Scoreboard monitor: consumes expected requests/writes/commits
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (exp_issue.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
                else check("mem_addr", 32'(mem_addr), 32'(exp_issue.pop_front()));
            end
            if (data_we) begin
                n_we++;
                if (exp_write.size() == 0) begin
                    check("write_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [15:0] ea;
                    ea = exp_write.pop_front();
                    check("fill_addr", 32'(addr_fsm), 32'(ea));
                    check("fill_data", 32'(data_fsm), 32'(mem_fn(ea)));
                end
            end else begin
                check("data_fsm_quiet", 32'(data_fsm), 32'd0);
            end
            if (metadata_we) begin
                n_meta++;
                if (exp_meta.size() == 0) check("meta_unexpected", 32'd1, 32'd0);
                else check("meta_addr", 32'(addr_fsm), 32'(exp_meta.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        int meta0;
        int n_late;
        int mcyc;

        rst       = 1'b1;
        miss      = 1'b0;
        miss_addr = 16'h0000;
        stray_v   = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Basic fill, cycle-exact timing for latency 4
        we0 = n_we; meta0 = n_meta;
        start_miss(16'h1236);
        tick();
        miss = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", k), 32'(fsm_busy), 32'(k <= 14));
            check($sformatf("mem_en_c%0d", k), 32'(mem_en), 32'(k <= 8));
            check($sformatf("data_we_c%0d", k), 32'(data_we), 32'(k >= 5 && k <= 12));
            check($sformatf("meta_we_c%0d", k), 32'(metadata_we), 32'(k == 13));
            tick();
        end
        check("basic_we_count", 32'(n_we - we0), 32'd8);
        check("basic_meta_count", 32'(n_meta - meta0), 32'd1);

        // Miss dropped in cycle 3 of a fill
        we0 = n_we; meta0 = n_meta;
        start_miss(16'hBEEE);
        tick(); tick(); tick();
        miss = 1'b0;
        miss_addr = 16'h7777;
        wait_idle();
        check("drop_we_count", 32'(n_we - we0), 32'd8);
        check("drop_meta_count", 32'(n_meta - meta0), 32'd1);

        // Reset in cycle 6 with requests in flight
        tick();
        start_miss(16'h2468);
        tick();
        miss = 1'b0;
        repeat (5) tick();
        #1;
        rst = 1'b1;
        exp_issue.delete();
        exp_write.delete();
        exp_meta.delete();
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        n_late = 0;
        we0 = n_we;
        for (int k = 7; k <= 11; k++) begin
            @(negedge clk);
            if (mem_data_valid) n_late++;
            check($sformatf("postrst_we_c%0d", k), 32'(data_we), 32'd0);
            check($sformatf("postrst_busy_c%0d", k), 32'(fsm_busy), 32'd0);
        end
        check("postrst_late_valids", 32'(n_late), 32'd3);
        check("postrst_no_write", 32'(n_we - we0), 32'd0);
        tick();
        we0 = n_we; meta0 = n_meta;
        start_miss(16'h3A5C);
        tick();
        miss = 1'b0;
        wait_idle();
        check("refill_we_count", 32'(n_we - we0), 32'd8);
        check("refill_meta_count", 32'(n_meta - meta0), 32'd1);

        // Stray valid in IDLE and a 9th valid after the block is complete
        tick();
        stray_v = 1'b1;
        @(negedge clk);
        check("stray_idle_we", 32'(data_we), 32'd0);
        check("stray_idle_busy", 32'(fsm_busy), 32'd0);
        tick();
        stray_v = 1'b0;
        @(negedge clk);
        check("stray_idle_after_busy", 32'(fsm_busy), 32'd0);
        tick();
        we0 = n_we;
        start_miss(16'h4C12);
        tick();
        miss = 1'b0;
        repeat (12) tick();
        stray_v = 1'b1;
        @(negedge clk);
        check("ninth_meta_we", 32'(metadata_we), 32'd1);
        check("ninth_data_we", 32'(data_we), 32'd0);
        tick();
        stray_v = 1'b0;
        wait_idle();
        check("ninth_we_count", 32'(n_we - we0), 32'd8);

        // Back-to-back misses with miss held high
        tick();
        we0 = n_we; meta0 = n_meta;
        start_miss(16'h0040);
        tick();
        miss_addr = 16'h0880;
        push_fill(16'h0880);
        wait_meta();
        @(negedge clk);
        check("b2b_settle_busy", 32'(fsm_busy), 32'd1);
        @(negedge clk);
        check("b2b_idle_busy", 32'(fsm_busy), 32'd0);
        check("b2b_idle_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("b2b_fill2_mem_en", 32'(mem_en), 32'd1);
        check("b2b_fill2_busy", 32'(fsm_busy), 32'd1);
        tick();
        miss = 1'b0;
        wait_meta();
        wait_idle();
        mcyc = n_meta - meta0;
        check("b2b_meta_count", 32'(mcyc), 32'd2);
        check("b2b_we_count", 32'(n_we - we0), 32'd16);

        check("issue_queue_empty", 32'(exp_issue.size()), 32'd0);
        check("write_queue_empty", 32'(exp_write.size()), 32'd0);
        check("meta_queue_empty", 32'(exp_meta.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that refills the instruction cache from main memory. It samples the cache's miss signal and the missing CPU address. It then streams the 8-word (16-byte) block from a pipelined memory, writing each returned word into the cache's fill port. It finishes with a single metadata-commit pulse. It sits between the instruction cache (its fill/write side) and the memory model, and stalls the fetch stage while busy.

## Interface
Parameters:
- ADDR_W, 16, address width in bits
- DATA_W, 16, data word width in bits
- BLOCK_WORDS, 8, words per cache block; fixed at 8 (offset = addr[3:1])

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- miss  in  1  cache miss indication (level)
- miss_addr  in  16  CPU address that missed
- fsm_busy  out  1  fill in progress; fetch stalls
- addr_fsm  out  16  cache fill address; word select = addr_fsm[3:1]
- data_fsm  out  16  cache fill data
- data_we  out  1  cache data write enable, one word per pulse
- metadata_we  out  1  cache metadata write enable, single-cycle pulse
- mem_en  out  1  memory read request
- mem_addr  out  16  memory read address
- mem_data  in  16  memory read data
- mem_data_valid  in  1  mem_data valid this cycle; fixed memory latency, in request order

## Operation
- States: IDLE, FILL, META, SETTLE.
- IDLE: if miss=1 at a clock edge, latch base = {miss_addr[15:4],4'b0} and crit = miss_addr[3:1]. Clear issue_cnt and recv_cnt (4-bit, range 0..8). Go to FILL.
- FILL, issue side:
  - While issue_cnt<8: mem_en=1, mem_addr = base | {word(issue_cnt),1'b0}, issue_cnt++.
  - At issue_cnt=8: mem_en=0.
- FILL, receive side:
  - On mem_data_valid with recv_cnt<8: data_we=1, addr_fsm = base | {word(recv_cnt),1'b0}, data_fsm=mem_data, recv_cnt++.
  - Issue and receive run concurrently.
- FILL→META on the edge where recv_cnt becomes 8.
- META: metadata_we=1 for exactly one cycle; addr_fsm=base. Then go to SETTLE.
- SETTLE: one idle cycle, because the cache commits metadata one cycle after metadata_we. Then go to IDLE; miss is re-sampled only in IDLE.
- fsm_busy=1 in FILL, META and SETTLE.
- word(i) = i[2:0] (see Configuration). Address arithmetic is a 3-bit offset OR-ed into the aligned base; no carry into bit 4.
- When data_we=0: data_fsm=0. addr_fsm=base in FILL/META/SETTLE and 0 in IDLE.
- Boundary conditions:
  - miss deasserting mid-fill: fill still completes.
  - mem_data_valid in IDLE/META/SETTLE, or with recv_cnt=8: ignored.
  - miss_addr changing after capture: ignored.
  - rst mid-fill: immediately returns to IDLE and clears counters; in-flight memory returns are then ignored as IDLE valids.
  - Back-to-back misses: the second fill starts no earlier than the cycle after SETTLE.

## Timing
- Reset values: state IDLE; fsm_busy, data_we, metadata_we, mem_en = 0; addr_fsm, data_fsm, mem_addr = 0.
- miss high at edge of cycle 0 → FILL in cycle 1.
- mem_en high cycles 1..8.
- With memory latency L: data_we in cycles 1+L..8+L, META in 9+L, SETTLE in 10+L, IDLE in 11+L. For L=4: fsm_busy high for 14 cycles (1..14).
- Outputs are combinational from state/counters/mem inputs. The cache samples them at the following edge.

## Configuration
- CACHE_FILL_CRIT_WORD_EN defined: critical-word-first wrap ordering, word(i) = (crit + i) mod 8. The missing word is requested and written first.
- Not defined: word(i) = i; the fill always starts at offset 0. crit is not stored.

## Structure
- Shared package cache_pkg holds:
  - state enum (IDLE, FILL, META, SETTLE)
  - BLOCK_WORDS, OFFSET_LSB=1, OFFSET_MSB=3
  - block-align mask
- These are reused by the cache and data-cache FSM.
- One natural sub-module: fill_word_counter (0..8 counter with done flag, instantiated twice for issue and receive).

## Test plan
- Miss at 0x1236, L=4, macro off → mem_addr 0x1230,0x1232…0x123E in cycles 1..8; data_we cycles 5..12 with matching addr_fsm; metadata_we only in cycle 13; fsm_busy low at cycle 15.
- Same miss with CACHE_FILL_CRIT_WORD_EN → order 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234; first data_we addr_fsm=0x1236.
- miss dropped in cycle 3 of a fill → all 8 data_we and one metadata_we still occur.
- rst pulsed in cycle 6 with requests in flight → all outputs 0 immediately; the 3 late mem_data_valid pulses cause no data_we; a later miss fills cleanly.
- Stray mem_data_valid in IDLE, and a 9th valid after 8 words → no data_we, state unchanged.
- miss held high continuously across two fills (0x0040 then 0x0880) → second FILL begins exactly one cycle after SETTLE; metadata_we pulses once per fill.
